// File: rtl/scratchpad_bd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scratchpad_bd_pkg
// Purpose  : Shared types for the scratchpad backdoor responder: FSM state
//            encoding, word size and the held backdoor request.
// Revision : 1.0 - initial release
// ============================================================================
package scratchpad_bd_pkg;

    localparam int WORD_BYTES  = 8;
    // Held addresses are zero-extended to this width so the struct does not
    // depend on the instantiating module's ADDR_W.
    localparam int BD_ADDR_MAX = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        RDATA = 2'd2,
        RSP   = 2'd3
    } bd_state_t;

    typedef struct packed {
        logic                   write;
        logic [BD_ADDR_MAX-1:0] addr;
        logic [63:0]            wdata;
        logic [7:0]             mask;
    } bd_req_t;

endpackage
`default_nettype wire

// File: rtl/scratchpad_bd_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : scratchpad_bd_starve_ctr
// Purpose  : Counts consecutive blocked backdoor cycles and raises starve
//            once the count reaches the programmed limit.
// Revision : 1.0 - initial release
// ============================================================================
module scratchpad_bd_starve_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    input  logic [7:0] limit,
    output logic       starve
);

    logic [7:0] count;

    // Count blocked cycles, holding at the limit; a grant clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (inc && (count != limit)) begin
            count <= count + 8'd1;
        end
    end

    assign starve = (count == limit);

endmodule
`default_nettype wire

// File: rtl/scratchpad_backdoor_responder.sv
`default_nettype none
// ============================================================================
// Module   : scratchpad_backdoor_responder
// Purpose  : Request/response backdoor port into the scratchpad SRAM,
//            arbitrated against functional traffic with starvation escape.
// Options  : SCRATCHPAD_BD_STATS_EN adds saturating access/preempt counters.
// Revision : 1.0 - initial release
// ============================================================================
module scratchpad_backdoor_responder
    import scratchpad_bd_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DEPTH        = 16384,
    parameter int IDX_W        = $clog2(DEPTH),
    parameter int STARVE_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bd_req_valid,
    output logic              bd_req_ready,
    input  logic              bd_req_write,
    input  logic [ADDR_W-1:0] bd_req_addr,
    input  logic [63:0]       bd_req_wdata,
    input  logic [7:0]        bd_req_mask,
    output logic              bd_rsp_valid,
    input  logic              bd_rsp_ready,
    output logic [63:0]       bd_rsp_rdata,
    output logic              bd_rsp_err,
    input  logic              fn_req_valid,
    output logic              fn_req_ready,
    input  logic              fn_req_write,
    input  logic [ADDR_W-1:0] fn_req_addr,
    input  logic [63:0]       fn_req_wdata,
    input  logic [7:0]        fn_req_mask,
    output logic [63:0]       fn_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [IDX_W-1:0]  mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_be,
    input  logic [63:0]       mem_rdata
`ifdef SCRATCHPAD_BD_STATS_EN
    ,
    output logic [31:0]       bd_wr_count,
    output logic [31:0]       bd_rd_count,
    output logic [31:0]       bd_preempt_count
`endif
);

    localparam int               OFF_W     = $clog2(WORD_BYTES);
    localparam logic [IDX_W:0]   DEPTH_EXT = (IDX_W+1)'(DEPTH);

    bd_state_t        state_q, state_d;
    bd_req_t          hold;
    logic [IDX_W-1:0] hold_idx;
    logic             in_range;
    logic             starve;
    logic             bd_grant;
    logic             fn_grant;
    logic             blocked;
    logic [63:0]      rsp_rdata_q;
    logic             rsp_err_q;
    logic             unused_bits;

    assign hold_idx = hold.addr[IDX_W+OFF_W-1:OFF_W];
    // Any address bit above the index field, or an index past DEPTH, is an error.
    assign in_range = ((hold.addr >> (IDX_W + OFF_W)) == '0) &&
                      ({1'b0, hold_idx} < DEPTH_EXT);

    assign fn_req_ready = !((state_q == PEND) && starve);
    assign bd_grant     = (state_q == PEND) && in_range && (!fn_req_valid || starve);
    assign fn_grant     = fn_req_valid && fn_req_ready && !bd_grant;
    assign blocked      = (state_q == PEND) && in_range && fn_req_valid && !starve;

    assign bd_req_ready = (state_q == IDLE) && !rst;
    assign bd_rsp_valid = (state_q == RSP);
    assign bd_rsp_rdata = rsp_rdata_q;
    assign bd_rsp_err   = rsp_err_q;
    assign fn_rdata     = mem_rdata;

    assign unused_bits  = ^{hold.addr[OFF_W-1:0], fn_req_addr[OFF_W-1:0],
                            fn_req_addr[ADDR_W-1:IDX_W+OFF_W]};

    scratchpad_bd_starve_ctr u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (blocked),
        .clr    (bd_grant),
        .limit  (8'(STARVE_LIMIT)),
        .starve (starve)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bd_req_valid) state_d = PEND;
            PEND: begin
                if (!in_range) begin
                    state_d = RSP;
                end else if (bd_grant) begin
                    state_d = hold.write ? RSP : RDATA;
                end
            end
            RDATA:   state_d = RSP;
            RSP:     if (bd_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Hold register and response payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold        <= '0;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            if ((state_q == IDLE) && bd_req_valid) begin
                hold.write  <= bd_req_write;
                hold.addr   <= BD_ADDR_MAX'(bd_req_addr);
                hold.wdata  <= bd_req_wdata;
                hold.mask   <= bd_req_mask;
                rsp_rdata_q <= 64'd0;
                rsp_err_q   <= 1'b0;
            end
            if ((state_q == PEND) && !in_range) begin
                rsp_err_q <= 1'b1;
            end
            // Only the backdoor's own read cycle is captured; later
            // functional reads on mem_rdata are ignored here.
            if (state_q == RDATA) begin
                rsp_rdata_q <= mem_rdata;
            end
        end
    end

    // SRAM port mux: backdoor when granted, otherwise functional pass-through.
    always_comb begin
        mem_req   = !rst && (bd_grant || fn_grant);
        mem_we    = 1'b0;
        mem_addr  = fn_req_addr[IDX_W+OFF_W-1:OFF_W];
        mem_wdata = fn_req_wdata;
        mem_be    = fn_req_mask;
        if (bd_grant) begin
            mem_addr  = hold_idx;
            mem_wdata = hold.wdata;
            mem_be    = hold.mask;
            mem_we    = mem_req && hold.write;
        end else begin
            mem_we    = mem_req && fn_req_write;
        end
    end

`ifdef SCRATCHPAD_BD_STATS_EN
    // Saturating backdoor access and starvation-preempt counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            bd_wr_count      <= 32'd0;
            bd_rd_count      <= 32'd0;
            bd_preempt_count <= 32'd0;
        end else if (bd_grant) begin
            if (hold.write && (bd_wr_count != 32'hFFFF_FFFF)) begin
                bd_wr_count <= bd_wr_count + 32'd1;
            end
            if (!hold.write && (bd_rd_count != 32'hFFFF_FFFF)) begin
                bd_rd_count <= bd_rd_count + 32'd1;
            end
            if (starve && (bd_preempt_count != 32'hFFFF_FFFF)) begin
                bd_preempt_count <= bd_preempt_count + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
